cc_orient_lock: RTL and testbench

- Parametrised successor to the two-line CC front end.
- Accepts NUM_CC already-buffered single-ended CC comparator lines and synchronises them.
- Detects which single line is active, debounces that choice, then locks orientation with an explicit FSM. While locked it steers BMC receive data from, and transmit data onto, only the locked line.
- Detects loss of attach and sits between the PHY pad buffers and the BMC codec.

---
 rtl/cc_orient_lock.sv | 143 ++++++++++++++
 tb/tb_cc_orient_lock.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cc_orient_lock.sv
// CC orientation lock: synchronises NUM_CC comparator lines, debounces a single active line,
// locks onto it and steers BMC rx/tx through it. Optional CC_FORCE_SEL_EN adds a forced-lock override.
module cc_orient_lock #(
   parameter int NUM_CC       = 2,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int DETACH_CYC   = 200000
) (
   input  logic              clock,
   input  logic              nrst,
   input  logic [NUM_CC-1:0] cc_in,
   input  logic              cc_dout,
   input  logic              cc_io_ctrl,
   input  logic              cc_check,
`ifdef CC_FORCE_SEL_EN
   input  logic              force_en,
   input  logic [NUM_CC-1:0] force_sel,
`endif
   output logic              cc_din,
   output logic              cc_lock,
   output logic [NUM_CC-1:0] cc_sel,
   output logic              cc_lost,
   output logic              phy_out_en,
   output logic [NUM_CC-1:0] phy_out_cc
);

   localparam int DBW = $clog2(DEBOUNCE_CYC) + 1;
   localparam int DTW = $clog2(DETACH_CYC) + 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_LOCKED   = 2'd2;

   localparam logic [NUM_CC-1:0] ONE     = NUM_CC'(1);
   localparam logic [DBW-1:0]    DB_LAST = DBW'(DEBOUNCE_CYC - 1);
   localparam logic [DTW-1:0]    DT_LAST = DTW'(DETACH_CYC - 1);

   logic [NUM_CC-1:0] cc_m;
   logic [NUM_CC-1:0] cc_s;
   logic [NUM_CC-1:0] cand;
   logic [1:0]        state;
   logic [DBW-1:0]    cnt;
   logic [DTW-1:0]    dcnt;
   logic              onehot;
   logic              line_low;
`ifdef CC_FORCE_SEL_EN
   logic              forced;
`endif

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         cc_m <= '0;
         cc_s <= '0;
      end else begin
         cc_m <= cc_in;
         cc_s <= cc_m;
      end
   end

   assign onehot   = (cc_s != '0) && ((cc_s & (cc_s - ONE)) == '0);
   assign line_low = !cc_io_ctrl && ((cc_s & cc_sel) == '0);

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state   <= ST_IDLE;
         cand    <= '0;
         cnt     <= '0;
         dcnt    <= '0;
         cc_sel  <= '0;
         cc_lock <= 1'b0;
         cc_lost <= 1'b0;
`ifdef CC_FORCE_SEL_EN
         forced  <= 1'b0;
`endif
      end else begin
         cc_lost <= 1'b0;
`ifdef CC_FORCE_SEL_EN
         // Override sits ahead of the normal FSM; its release drops straight back to IDLE.
         forced <= force_en;
         if (force_en) begin
            state   <= ST_LOCKED;
            cc_sel  <= force_sel;
            cc_lock <= |force_sel;
            cnt     <= '0;
            dcnt    <= '0;
         end else if (forced) begin
            state   <= ST_IDLE;
            cc_sel  <= '0;
            cc_lock <= 1'b0;
            dcnt    <= '0;
         end else
`endif
         begin
            case (state)
               ST_IDLE: begin
                  if (cc_check && !cc_io_ctrl && onehot) begin
                     cand  <= cc_s;
                     cnt   <= '0;
                     state <= ST_DEBOUNCE;
                  end
               end
               ST_DEBOUNCE: begin
                  if (cc_io_ctrl || !cc_check || (cc_s != cand)) begin
                     state <= ST_IDLE;
                  end else if (cnt == DB_LAST) begin
                     cc_sel  <= cand;
                     cc_lock <= 1'b1;
                     dcnt    <= '0;
                     state   <= ST_LOCKED;
                  end else if (cnt != '1) begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_LOCKED: begin
                  if (!line_low) begin
                     dcnt <= '0;
                  end else if (dcnt == DT_LAST) begin
                     cc_sel  <= '0;
                     cc_lock <= 1'b0;
                     cc_lost <= 1'b1;
                     dcnt    <= '0;
                     state   <= ST_IDLE;
                  end else if (dcnt != '1) begin
                     dcnt <= dcnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      cc_din = |cc_s;
      if (cc_io_ctrl)
         cc_din = 1'b1;
      else if (state == ST_LOCKED)
         cc_din = |(cc_s & cc_sel);
   end

   assign phy_out_en = !cc_io_ctrl;
   assign phy_out_cc = cc_sel & {NUM_CC{cc_dout & cc_io_ctrl}};

endmodule

// File: tb/tb_cc_orient_lock.sv
// Randomised and directed bench for cc_orient_lock (NUM_CC=2, DEBOUNCE_CYC=8, DETACH_CYC=16)
// compared every cycle against a run-length behavioural model.
module tb_cc_orient_lock;

   localparam int N  = 2;
   localparam int DB = 8;
   localparam int DT = 16;

   logic         clock = 1'b0;
   logic         nrst;
   logic [N-1:0] cc_in;
   logic         cc_dout, cc_io_ctrl, cc_check;
   logic         cc_din, cc_lock, cc_lost, phy_out_en;
   logic [N-1:0] cc_sel, phy_out_cc;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clock = ~clock;

   cc_orient_lock #(.NUM_CC(N), .DEBOUNCE_CYC(DB), .DETACH_CYC(DT)) dut (
      .clock(clock), .nrst(nrst), .cc_in(cc_in), .cc_dout(cc_dout),
      .cc_io_ctrl(cc_io_ctrl), .cc_check(cc_check),
`ifdef CC_FORCE_SEL_EN
      .force_en(1'b0), .force_sel(2'b00),
`endif
      .cc_din(cc_din), .cc_lock(cc_lock), .cc_sel(cc_sel), .cc_lost(cc_lost),
      .phy_out_en(phy_out_en), .phy_out_cc(phy_out_cc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: m_sel nonzero means locked; searches are tracked as a run of agreeing cycles.
   bit [N-1:0] m_s1, m_s2, m_cand, m_sel;
   bit         m_searching, m_lost;
   int         m_run, m_low;

   always @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         m_s1 = '0; m_s2 = '0; m_cand = '0; m_sel = '0;
         m_searching = 0; m_lost = 0; m_run = 0; m_low = 0;
      end else begin
         m_lost = 0;
         if (m_sel != 0) begin
            if (!cc_io_ctrl && (m_s2 & m_sel) == 0) m_low++;
            else m_low = 0;
            if (m_low == DT) begin
               m_sel = '0; m_lost = 1; m_low = 0;
            end
         end else if (m_searching) begin
            if (cc_io_ctrl || !cc_check || m_s2 != m_cand) m_searching = 0;
            else begin
               m_run++;
               if (m_run == DB) begin
                  m_sel = m_cand; m_searching = 0; m_low = 0;
               end
            end
         end else if (cc_check && !cc_io_ctrl && $countones(m_s2) == 1) begin
            m_searching = 1; m_cand = m_s2; m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = cc_in;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         logic exp_din;
         exp_din = cc_io_ctrl ? 1'b1 : ((m_sel != 0) ? |(m_s2 & m_sel) : |m_s2);
         check("lock", 32'(cc_lock), 32'(m_sel != 0));
         check("sel", 32'(cc_sel), 32'(m_sel));
         check("lost", 32'(cc_lost), 32'(m_lost));
         check("din", 32'(cc_din), 32'(exp_din));
         check("out_en", 32'(phy_out_en), 32'(!cc_io_ctrl));
         check("out_cc", 32'(phy_out_cc), 32'(m_sel & {N{cc_dout & cc_io_ctrl}}));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic edge_neg;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic b[0:39];
      int lost_cnt;

      nrst = 1'b0; cc_in = 2'b01; cc_dout = 1'b0; cc_io_ctrl = 1'b0; cc_check = 1'b0;

      // 1: reset state, then idle with cc_check low
      repeat (3) @(negedge clock);
      check("rst_lock", 32'(cc_lock), 32'd0);
      check("rst_sel", 32'(cc_sel), 32'd0);
      check("rst_lost", 32'(cc_lost), 32'd0);
      check("rst_phy", 32'(phy_out_cc), 32'd0);
      @(posedge clock); #2;
      nrst = 1'b1;
      chk_en = 1'b1;
      tick(10);
      cc_in = 2'b00;
      tick(10);
      check("nocheck_lock", 32'(cc_lock), 32'd0);

      // 2: lock on line 1; sync (2) + IDLE->DEBOUNCE (1) + debounce (8)
      cc_check = 1'b1; cc_in = 2'b10;
      for (int k = 1; k <= 11; k++) begin
         edge_neg();
         if (k == 10) check("lock_early", 32'(cc_lock), 32'd0);
         if (k == 11) begin
            check("lock_on_time", 32'(cc_lock), 32'd1);
            check("lock_sel10", 32'(cc_sel), 32'h2);
         end
      end
      @(posedge clock); #2;
      cc_io_ctrl = 1'b1; cc_dout = 1'b1;
      @(negedge clock);
      check("tx_phy", 32'(phy_out_cc), 32'h2);
      check("tx_en", 32'(phy_out_en), 32'd0);
      check("tx_din", 32'(cc_din), 32'd1);
      @(posedge clock); #2;
      cc_io_ctrl = 1'b0; cc_dout = 1'b0;

      // 3: aborted debounce, then lock on line 0
      cc_in = 2'b00;
      tick(20);
      check("detach_a", 32'(cc_lock), 32'd0);
      cc_in = 2'b01;
      tick(5);
      cc_in = 2'b11;
      tick(10);
      check("both_nolock", 32'(cc_lock), 32'd0);
      cc_in = 2'b01;
      for (int k = 1; k <= 11; k++) begin
         edge_neg();
         if (k == 10) check("relock_early", 32'(cc_lock), 32'd0);
      end
      check("relock_sel01", 32'(cc_sel), 32'h1);

      // 4: 15 low cycles hold the lock, 16+ detach with one cc_lost pulse
      @(posedge clock); #2;
      cc_in = 2'b00;
      tick(15);
      cc_in = 2'b01;
      tick(6);
      check("low15_lock", 32'(cc_lock), 32'd1);
      cc_in = 2'b00;
      lost_cnt = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clock);
         if (cc_lost) lost_cnt++;
      end
      check("lost_pulses", 32'(lost_cnt), 32'd1);
      check("detach_lock", 32'(cc_lock), 32'd0);
      check("detach_sel", 32'(cc_sel), 32'd0);

      // 5: locked on line 1, BMC on line 1 with line 0 held high
      @(posedge clock); #2;
      cc_in = 2'b10;
      tick(12);
      check("bmc_sel", 32'(cc_sel), 32'h2);
      for (int i = 0; i < 40; i++) begin
         b[i] = (i % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         cc_in = {b[i], 1'b1};
         @(negedge clock);
         if (i >= 2) check("bmc_din", 32'(cc_din), 32'(b[i-2]));
         @(posedge clock); #2;
      end
      cc_in = 2'b00;
      tick(20);

      // 7: randomised held patterns with occasional transmit and check toggles
      for (int seg = 0; seg < 60; seg++) begin
         cc_in      = 2'($urandom_range(0, 3));
         cc_io_ctrl = ($urandom_range(0, 7) == 0);
         cc_check   = ($urandom_range(0, 5) != 0);
         cc_dout    = 1'($urandom_range(0, 1));
         tick($urandom_range(1, 25));
      end
      cc_io_ctrl = 1'b0; cc_check = 1'b1; cc_in = 2'b00;
      tick(20);

      // 6: async reset mid-debounce, then the full debounce again
      cc_in = 2'b01;
      for (int k = 1; k <= 8; k++) edge_neg();
      check("mid_deb_lock", 32'(cc_lock), 32'd0);
      #2 nrst = 1'b0;
      #1;
      check("arst_lock", 32'(cc_lock), 32'd0);
      check("arst_sel", 32'(cc_sel), 32'd0);
      check("arst_lost", 32'(cc_lost), 32'd0);
      check("arst_phy", 32'(phy_out_cc), 32'd0);
      check("arst_din", 32'(cc_din), 32'd0);
      @(posedge clock); @(posedge clock); #2;
      nrst = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         edge_neg();
         if (k == 10) check("post_rst_early", 32'(cc_lock), 32'd0);
      end
      check("post_rst_lock", 32'(cc_lock), 32'd1);
      check("post_rst_sel", 32'(cc_sel), 32'h1);

      tick(2);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
